// File: rtl/align_sequencer_if.sv
// Bundle between the alignment sequencer and its controller / delay_ctrl bank.
// master = the sequencer itself, slave = whatever drives and observes it.
interface align_sequencer_if #(
  parameter int unsigned NCH = 8
);
  logic                 start;
  logic                 abort;
  logic [NCH-1:0]       chan_mask;
  logic [5:0]           min_eye;
  logic [1:0]           max_retries;
  logic                 keep_tracking;
  logic [NCH-1:0]       delay_ready;
  logic [6*NCH-1:0]     eye_width;
  logic [NCH-1:0]       delay_mode;
  logic [NCH-1:0]       reset_counters;
  logic                 busy;
  logic                 done;
  logic [NCH-1:0]       chan_ok;
  logic [NCH-1:0]       chan_fail;
  logic [6*NCH-1:0]     eye_table;

  modport master (
    input  start, abort, chan_mask, min_eye, max_retries, keep_tracking,
           delay_ready, eye_width,
    output delay_mode, reset_counters, busy, done, chan_ok, chan_fail, eye_table
  );

  modport slave (
    output start, abort, chan_mask, min_eye, max_retries, keep_tracking,
           delay_ready, eye_width,
    input  delay_mode, reset_counters, busy, done, chan_ok, chan_fail, eye_table
  );
endinterface

// File: rtl/align_sequencer.sv
// Sweeps delay_ctrl channels one at a time: enable auto mode, wait for lock,
// let the eye settle, then grade the captured eye_width against min_eye.
module align_sequencer #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned TIMEOUT = 20'hFFFFF,
  parameter int unsigned SETTLE  = 32
) (
  input logic               clk160,
  input logic               rst,
  align_sequencer_if.master bus
);
  localparam int unsigned HOLD_LEN = 8;
  localparam int unsigned MAX_TS   = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int unsigned CNT_MAX  = (MAX_TS > HOLD_LEN) ? MAX_TS : HOLD_LEN;
  localparam int unsigned CNTW     = $clog2(CNT_MAX + 1);
  localparam int unsigned IDXW     = $clog2(NCH + 1);
  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_ARM, S_WAIT_LOW, S_WAIT_HIGH,
    S_SETTLE, S_CHECK, S_HOLD, S_RELEASE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0]   delay_mode_q, delay_mode_d;
  logic [NCH-1:0]   reset_counters_q, reset_counters_d;
  logic [NCH-1:0]   chan_ok_q, chan_ok_d;
  logic [NCH-1:0]   chan_fail_q, chan_fail_d;
  logic [5:0]       eye_table_q [NCH];
  logic [5:0]       eye_table_d [NCH];
  logic [5:0]       eye_in [NCH];
  logic [CHW-1:0]   ch;
  logic             idx_end;
  logic             attempt_fail;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_eye
      assign eye_in[gi]                 = bus.eye_width[6*gi +: 6];
      assign bus.eye_table[6*gi +: 6]   = eye_table_q[gi];
    end
  endgenerate

  assign ch      = idx_q[CHW-1:0];
  assign idx_end = (idx_q == IDXW'(NCH));

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    retry_d          = retry_q;
    cnt_d            = cnt_q;
    delay_mode_d     = delay_mode_q;
    reset_counters_d = '0;
    chan_ok_d        = chan_ok_q;
    chan_fail_d      = chan_fail_q;
    eye_table_d      = eye_table_q;
    attempt_fail     = 1'b0;

    // Abort leaves completed channels' flags and tracking untouched.
    if (bus.abort && state_q != S_IDLE && state_q != S_DONE) begin
      if (!idx_end) delay_mode_d[ch] = 1'b0;
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          chan_ok_d   = '0;
          chan_fail_d = '0;
          retry_d     = '0;
          idx_d       = '0;
          state_d     = S_SELECT;
        end
        S_SELECT: begin
          if (idx_end)                 state_d = S_DONE;
          else if (bus.chan_mask[ch])  state_d = S_ARM;
          else                         idx_d   = idx_q + 1'b1;
        end
        S_ARM: begin
          delay_mode_d[ch] = 1'b1;
          cnt_d            = CNTW'(TIMEOUT);
          state_d          = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!bus.delay_ready[ch]) begin
            cnt_d   = CNTW'(TIMEOUT);
            state_d = S_WAIT_HIGH;
          end else if (cnt_q <= CNTW'(1)) attempt_fail = 1'b1;
          else cnt_d = cnt_q - 1'b1;
        end
        S_WAIT_HIGH: begin
          if (bus.delay_ready[ch]) begin
            cnt_d   = CNTW'(SETTLE);
            state_d = S_SETTLE;
          end else if (cnt_q <= CNTW'(1)) attempt_fail = 1'b1;
          else cnt_d = cnt_q - 1'b1;
        end
        S_SETTLE: begin
          if (cnt_q <= CNTW'(1)) begin
            eye_table_d[ch] = eye_in[ch];
            state_d         = S_CHECK;
          end else cnt_d = cnt_q - 1'b1;
        end
        S_CHECK: begin
          if (eye_table_q[ch] >= bus.min_eye) begin
            chan_ok_d[ch]        = 1'b1;
            reset_counters_d[ch] = 1'b1;
            state_d              = S_RELEASE;
          end else attempt_fail = 1'b1;
        end
        // The following ARM cycle is the last of the HOLD_LEN low cycles.
        S_HOLD: begin
          if (cnt_q <= CNTW'(1)) state_d = S_ARM;
          else                   cnt_d   = cnt_q - 1'b1;
        end
        S_RELEASE: begin
          delay_mode_d[ch] = chan_ok_q[ch] & bus.keep_tracking;
          retry_d          = '0;
          idx_d            = idx_q + 1'b1;
          state_d          = S_SELECT;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (attempt_fail) begin
        if (retry_q < bus.max_retries) begin
          retry_d          = retry_q + 1'b1;
          delay_mode_d[ch] = 1'b0;
          cnt_d            = CNTW'(HOLD_LEN - 1);
          state_d          = S_HOLD;
        end else begin
          chan_fail_d[ch] = 1'b1;
          state_d         = S_RELEASE;
        end
      end
    end
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      retry_q          <= '0;
      cnt_q            <= '0;
      delay_mode_q     <= '0;
      reset_counters_q <= '0;
      chan_ok_q        <= '0;
      chan_fail_q      <= '0;
      eye_table_q      <= '{default: '0};
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      retry_q          <= retry_d;
      cnt_q            <= cnt_d;
      delay_mode_q     <= delay_mode_d;
      reset_counters_q <= reset_counters_d;
      chan_ok_q        <= chan_ok_d;
      chan_fail_q      <= chan_fail_d;
      eye_table_q      <= eye_table_d;
    end
  end

  assign bus.delay_mode     = delay_mode_q;
  assign bus.reset_counters = reset_counters_q;
  assign bus.chan_ok        = chan_ok_q;
  assign bus.chan_fail      = chan_fail_q;
  assign bus.busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done           = (state_q == S_DONE);
endmodule

// File: tb/tb_align_sequencer.sv
// Bench for align_sequencer: emulated delay_ctrl bank, table vectors,
// randomized sweeps against a per-channel attempt model, and corner sequences.
module tb_align_sequencer;
  localparam int NCH     = 8;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 32;

  logic clk160 = 1'b0;
  logic rst;
  always #5 clk160 = ~clk160;

  align_sequencer_if #(.NCH(NCH)) bus ();
  align_sequencer #(.NCH(NCH), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk160(clk160), .rst(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // delay_ctrl emulation settings (written by the stimulus process)
  logic [NCH-1:0] stuck = '0;
  int             lock_delay [NCH];
  logic [5:0]     eye_att [NCH][4];

  // monitor / emulator state (written only by the negedge process)
  logic [NCH-1:0]   rdy  = '0;
  logic [6*NCH-1:0] eyew = '0;
  logic [NCH-1:0]   prev_mode = '0;
  int rises [NCH];
  int rc_cnt [NCH];
  int lock_cnt [NCH];
  int low_run [NCH];
  int high_run [NCH];
  int last_high [NCH];
  int gap_before [NCH][4];
  int done_cnt = 0;
  int viol_cnt = 0;

  assign bus.delay_ready = rdy;
  assign bus.eye_width   = eyew;

  always @(negedge clk160) begin
    if (bus.start === 1'b1) begin
      done_cnt = 0;
      viol_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
        rises[i] = 0;
        rc_cnt[i] = 0;
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    if ($countones(bus.delay_mode ^ prev_mode) > 1) viol_cnt++;
    if ((bus.chan_ok & bus.chan_fail) != '0) viol_cnt++;
    for (int i = 0; i < NCH; i++) begin
      int att;
      if (bus.reset_counters[i]) rc_cnt[i]++;
      if (bus.delay_mode[i] && !prev_mode[i]) begin
        if (rises[i] < 4) gap_before[i][rises[i]] = low_run[i];
        rises[i]++;
        lock_cnt[i] = lock_delay[i];
      end
      if (bus.delay_mode[i]) begin
        high_run[i]++;
        low_run[i] = 0;
      end else begin
        if (prev_mode[i]) last_high[i] = high_run[i];
        high_run[i] = 0;
        low_run[i]++;
      end
      if (stuck[i])                rdy[i] = 1'b1;
      else if (!bus.delay_mode[i]) rdy[i] = 1'b0;
      else if (lock_cnt[i] > 0) begin
        lock_cnt[i]--;
        rdy[i] = 1'b0;
      end else rdy[i] = 1'b1;
      att = (rises[i] == 0) ? 0 : rises[i] - 1;
      if (att > 3) att = 3;
      eyew[6*i +: 6] = eye_att[i][att];
    end
    prev_mode = bus.delay_mode;
  end

  // reference model: outcome of each channel computed from its attempt list
  logic [NCH-1:0] exp_ok, exp_fail, exp_mode;
  int             exp_rises [NCH];
  logic [5:0]     model_eye [NCH];
  int             guard;

  task automatic tick();
    @(posedge clk160);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_chan(input int i, input logic [5:0] eye, input int lock, input logic stk);
    for (int a = 0; a < 4; a++) eye_att[i][a] = eye;
    lock_delay[i] = lock;
    stuck[i] = stk;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) model_eye[i] = '0;
  endtask

  task automatic model_sweep(input logic [NCH-1:0] mask, input logic [5:0] mn,
                             input logic [1:0] mr, input logic kt);
    for (int i = 0; i < NCH; i++) begin
      bit passed = 0;
      exp_rises[i] = 0;
      exp_ok[i] = 1'b0;
      exp_fail[i] = 1'b0;
      if (mask[i]) begin
        for (int a = 0; a <= int'(mr) && !passed; a++) begin
          exp_rises[i]++;
          if (!(stuck[i] || lock_delay[i] >= 100)) begin
            model_eye[i] = eye_att[i][a];
            if (model_eye[i] >= mn) passed = 1;
          end
        end
        exp_ok[i] = passed;
        exp_fail[i] = !passed;
      end
    end
    exp_mode = exp_ok & {NCH{kt}};
  endtask

  function automatic logic [6*NCH-1:0] model_table();
    logic [6*NCH-1:0] t;
    for (int i = 0; i < NCH; i++) t[6*i +: 6] = model_eye[i];
    return t;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic launch(input logic [NCH-1:0] mask, input logic [5:0] mn,
                        input logic [1:0] mr, input logic kt);
    bus.chan_mask = mask;
    bus.min_eye = mn;
    bus.max_retries = mr;
    bus.keep_tracking = kt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Runs one full sweep and compares every observable result with the model.
  task automatic do_sweep(input string tag, input logic [NCH-1:0] mask, input logic [5:0] mn,
                          input logic [1:0] mr, input logic kt);
    model_sweep(mask, mn, mr, kt);
    launch(mask, mn, mr, kt);
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      tick();
      guard++;
    end
    tick();
    tick();
    $display("sweep %s: mask=%02h min=%0d retries=%0d kt=%0d ok=%02h fail=%02h mode=%02h",
             tag, mask, mn, mr, kt, bus.chan_ok, bus.chan_fail, bus.delay_mode);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".chan_ok"}, bus.chan_ok, exp_ok);
    check({tag, ".chan_fail"}, bus.chan_fail, exp_fail);
    check({tag, ".delay_mode"}, bus.delay_mode, exp_mode);
    check({tag, ".eye_table"}, bus.eye_table, model_table());
    check({tag, ".invariants"}, viol_cnt, 0);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("%s.arms_ch%0d", tag, i), rises[i], exp_rises[i]);
      check($sformatf("%s.rc_pulses_ch%0d", tag, i), rc_cnt[i], exp_ok[i] ? 1 : 0);
    end
  endtask

  typedef struct {
    logic [NCH-1:0]   mask;
    logic [5:0]       mn;
    logic [1:0]       mr;
    logic             kt;
    logic [6*NCH-1:0] eyes;
    logic [NCH-1:0]   stk;
    logic [NCH-1:0]   ok;
    logic [NCH-1:0]   fail;
    logic [NCH-1:0]   mode;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{8'h05, 6'd10, 2'd0, 1'b0, {8{6'd20}}, 8'h00, 8'h05, 8'h00, 8'h00};
    vt[1] = '{8'hFF, 6'd10, 2'd0, 1'b1, {8{6'd20}}, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vt[2] = '{8'hFF, 6'd10, 2'd0, 1'b0, {8{6'd20}}, 8'h00, 8'hFF, 8'h00, 8'h00};
    vt[3] = '{8'h0F, 6'd21, 2'd0, 1'b0,
              {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd20, 6'd21}, 8'h00, 8'h05, 8'h0A, 8'h00};
    vt[4] = '{8'hF0, 6'd0, 2'd0, 1'b0, {8{6'd0}}, 8'h00, 8'hF0, 8'h00, 8'h00};
    vt[5] = '{8'h00, 6'd10, 2'd3, 1'b1, {8{6'd40}}, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[6] = '{8'h81, 6'd10, 2'd1, 1'b0, {8{6'd30}}, 8'h80, 8'h01, 8'h80, 8'h00};

    for (int i = 0; i < NCH; i++) begin
      set_chan(i, 6'd0, 10, 1'b0);
      rises[i] = 0; rc_cnt[i] = 0; lock_cnt[i] = 0;
      low_run[i] = 0; high_run[i] = 0; last_high[i] = 0;
      for (int a = 0; a < 4; a++) gap_before[i][a] = 0;
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.chan_mask = '0;
    bus.min_eye = '0; bus.max_retries = '0; bus.keep_tracking = 1'b0;

    // reset dominates start and abort
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(); tick(); tick();
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.delay_mode", bus.delay_mode, 0);
    check("rst.reset_counters", bus.reset_counters, 0);
    check("rst.chan_ok", bus.chan_ok, 0);
    check("rst.chan_fail", bus.chan_fail, 0);
    check("rst.eye_table", bus.eye_table, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    check("idle.busy", bus.busy, 0);

    // table vectors
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NCH; i++) set_chan(i, vt[v].eyes[6*i +: 6], (v == 0) ? 50 : 10, vt[v].stk[i]);
      do_sweep($sformatf("tbl%0d", v), vt[v].mask, vt[v].mn, vt[v].mr, vt[v].kt);
      check($sformatf("tbl%0d.ok", v), bus.chan_ok, vt[v].ok);
      check($sformatf("tbl%0d.fail", v), bus.chan_fail, vt[v].fail);
      check($sformatf("tbl%0d.mode", v), bus.delay_mode, vt[v].mode);
      if (vt[v].mode != '0) apply_reset();
    end
    stuck = '0;

    // three attempts on a low eye with an 8-cycle low gap before each retry
    for (int i = 0; i < NCH; i++) set_chan(i, 6'd9, 10, 1'b0);
    do_sweep("retry", 8'h01, 6'd10, 2'd2, 1'b0);
    check("retry.gap1", gap_before[0][1], 8);
    check("retry.gap2", gap_before[0][2], 8);
    check("retry.fail0", bus.chan_fail[0], 1);

    // stuck ready: a WAIT_LOW timeout keeps the previously captured eye
    set_chan(1, 6'd25, 10, 1'b0);
    do_sweep("pre_timeout", 8'h02, 6'd10, 2'd0, 1'b0);
    set_chan(1, 6'd50, 10, 1'b1);
    do_sweep("timeout", 8'h02, 6'd10, 2'd0, 1'b0);
    check("timeout.mode_high_cycles", last_high[1], TIMEOUT + 1);
    check("timeout.eye_ch1", bus.eye_table[11:6], 25);
    stuck = '0;

    // abort while channel 3 settles
    for (int i = 0; i < NCH; i++) set_chan(i, 6'd30, 10, 1'b0);
    launch(8'h0F, 6'd10, 2'd0, 1'b1);
    guard = 0;
    while (!(bus.delay_mode[3] && rdy[3]) && guard < 2000) begin
      tick();
      guard++;
    end
    check("abort.reach_ch3", guard < 2000, 1);
    tick(); tick(); tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    $display("abort: ok=%02h fail=%02h mode=%02h done=%0d", bus.chan_ok, bus.chan_fail, bus.delay_mode, bus.done);
    check("abort.done", bus.done, 1);
    check("abort.chan_ok", bus.chan_ok, 8'h07);
    check("abort.chan_fail", bus.chan_fail, 8'h00);
    check("abort.delay_mode", bus.delay_mode, 8'h07);
    check("abort.eye_ch0_2", bus.eye_table[17:0], {3{6'd30}});
    tick();
    check("abort.done_once", bus.done, 0);
    check("abort.busy", bus.busy, 0);
    apply_reset();

    // start while busy is ignored, then reset mid-sweep clears tracked modes
    launch(8'hFF, 6'd10, 2'd0, 1'b1);
    guard = 0;
    while (!bus.delay_mode[2] && guard < 2000) begin
      tick();
      guard++;
    end
    check("midrst.reach_ch2", guard < 2000, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start.chan_ok", bus.chan_ok, 8'h03);
    check("busy_start.busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    $display("midrst: mode=%02h ok=%02h busy=%0d", bus.delay_mode, bus.chan_ok, bus.busy);
    check("midrst.delay_mode", bus.delay_mode, 0);
    check("midrst.chan_ok", bus.chan_ok, 0);
    check("midrst.eye_table", bus.eye_table, 0);
    check("midrst.busy", bus.busy, 0);
    rst = 1'b0;
    model_reset();
    tick();

    // randomized sweeps against the model
    for (int r = 0; r < 12; r++) begin
      logic [NCH-1:0] m;
      logic [5:0]     mn;
      logic [1:0]     mr;
      logic           kt;
      m  = NCH'($urandom);
      mn = 6'($urandom_range(0, 40));
      mr = 2'($urandom_range(0, 3));
      kt = 1'($urandom_range(0, 1));
      for (int i = 0; i < NCH; i++) begin
        for (int a = 0; a < 4; a++) eye_att[i][a] = 6'($urandom_range(0, 63));
        lock_delay[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 120) : $urandom_range(2, 40);
        stuck[i] = ($urandom_range(0, 9) == 0);
      end
      do_sweep($sformatf("rnd%0d", r), m, mn, mr, kt);
      if (exp_mode != '0) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
